// File: rtl/mem_pkg.sv
// Shared definitions for the RAM port arbiter slice.
//   SZ_B / SZ_H / SZ_W : load/store access size encodings (2'b11 is illegal)
//   state_t            : arbiter FSM states
//   port_t             : which requester owns the in-flight access
package mem_pkg;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic {IDLE, ACCESS} state_t;
  typedef enum logic {PORT_IF, PORT_LS} port_t;
endpackage

// File: rtl/ram_port_arbiter_if.sv
// CPU-side bus of the RAM port arbiter: fetch and load/store request
// handshakes plus their one-cycle response pulses.
//   master : CPU core side (drives requests, receives responses)
//   slave  : arbiter side (accepts requests, drives responses)
interface ram_port_arbiter_if #(parameter int ADDR_W = 24);
  logic              if_req_valid;
  logic              if_req_ready;
  logic [ADDR_W+1:0] if_addr;
  logic              if_resp_valid;
  logic [31:0]       if_resp_data;
  logic              if_err;

  logic              ls_req_valid;
  logic              ls_req_ready;
  logic [ADDR_W+1:0] ls_addr;
  logic              ls_we;
  logic [1:0]        ls_size;
  logic              ls_unsigned;
  logic [31:0]       ls_wdata;
  logic              ls_resp_valid;
  logic [31:0]       ls_resp_data;
  logic              ls_err;

  modport master (
    output if_req_valid, if_addr,
    output ls_req_valid, ls_addr, ls_we, ls_size, ls_unsigned, ls_wdata,
    input  if_req_ready, if_resp_valid, if_resp_data, if_err,
    input  ls_req_ready, ls_resp_valid, ls_resp_data, ls_err
  );

  modport slave (
    input  if_req_valid, if_addr,
    input  ls_req_valid, ls_addr, ls_we, ls_size, ls_unsigned, ls_wdata,
    output if_req_ready, if_resp_valid, if_resp_data, if_err,
    output ls_req_ready, ls_resp_valid, ls_resp_data, ls_err
  );
endinterface

// File: rtl/ram_port_arbiter_lane_align.sv
// mem_lane_align: purely combinational byte-lane logic for one access.
//   off, size, uns : byte offset in word, access size, zero-extend flag
//   wdata          : low-aligned store data -> wdata_rep (replicated to all lanes)
//   rdata          : raw RAM word -> rdata_ext (shifted down and extended)
//   mask           : byte-lane enables; misalign flags an illegal access
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  mask,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misalign
);
  logic [31:0] sh;

  assign sh = rdata >> {off, 3'b000};

  always_comb begin
    mask      = 4'b0000;
    wdata_rep = '0;
    rdata_ext = '0;
    misalign  = 1'b0;
    case (size)
      SZ_B: begin
        mask      = 4'b0001 << off;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      end
      SZ_H: begin
        mask      = 4'b0011 << off;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
        misalign  = off[0];
      end
      SZ_W: begin
        mask      = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = sh;
        misalign  = (off != 2'b00);
      end
      default: misalign = 1'b1;
    endcase
  end
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares a single-port 32-bit RAM between instruction
// fetch and load/store with round-robin arbitration. Each access takes one
// IDLE (handshake) cycle and one ACCESS cycle; the response is registered
// and pulses in the cycle after ACCESS.
//   clk, rst     : clock, asynchronous active-high reset
//   bus          : CPU-side request/response interface (slave modport)
//   ram_*        : RAM drive (address, write data, lane enables, write enable)
//   ram_data_out : combinational RAM read data
module ram_port_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  ram_port_arbiter_if.slave bus,
  output logic [ADDR_W-1:0] ram_sel_addr,
  output logic [31:0]       ram_data_in,
  output logic [3:0]        ram_wbyte_enable,
  output logic [3:0]        ram_rbyte_enable,
  output logic              ram_wen,
  input  logic [31:0]       ram_data_out
);
  typedef struct packed {
    port_t             port;
    logic [ADDR_W+1:0] addr;
    logic              we;
    logic [1:0]        size;
    logic              uns;
    logic [31:0]       wdata;
  } req_t;

  state_t      state, state_n;
  req_t        req_q;
  logic        last_if, grant_if, accept;
  logic [3:0]  mask;
  logic [31:0] wdata_rep, rdata_ext;
  logic        misalign;

  // Lone requester wins; on a tie the port not served last wins.
  always_comb begin
    grant_if = 1'b1;
    if (bus.if_req_valid && bus.ls_req_valid) grant_if = !last_if;
    else if (bus.ls_req_valid)                grant_if = 1'b0;
  end

  assign accept = (state == IDLE) &&
                  (grant_if ? bus.if_req_valid : bus.ls_req_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n          = state;
    bus.if_req_ready = 1'b0;
    bus.ls_req_ready = 1'b0;
    ram_wen          = 1'b0;
    ram_wbyte_enable = 4'b0000;
    ram_rbyte_enable = 4'b0000;
    ram_data_in      = '0;
    case (state)
      IDLE: begin
        bus.if_req_ready = grant_if;
        bus.ls_req_ready = !grant_if;
        if (accept) state_n = ACCESS;
      end
      ACCESS: begin
        state_n = IDLE;
        // A misaligned access never touches the RAM.
        if (!misalign) begin
          if (req_q.we) begin
            ram_wen          = 1'b1;
            ram_wbyte_enable = mask;
            ram_data_in      = wdata_rep;
          end else begin
            ram_rbyte_enable = mask;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Fetch is latched as an unextended word read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q   <= '0;
      last_if <= 1'b0;
    end else if (accept) begin
      last_if <= grant_if;
      if (grant_if) begin
        req_q.port  <= PORT_IF;
        req_q.addr  <= bus.if_addr;
        req_q.we    <= 1'b0;
        req_q.size  <= SZ_W;
        req_q.uns   <= 1'b0;
        req_q.wdata <= '0;
      end else begin
        req_q.port  <= PORT_LS;
        req_q.addr  <= bus.ls_addr;
        req_q.we    <= bus.ls_we;
        req_q.size  <= bus.ls_size;
        req_q.uns   <= bus.ls_unsigned;
        req_q.wdata <= bus.ls_wdata;
      end
    end
  end

  assign ram_sel_addr = req_q.addr[ADDR_W+1:2];

  mem_lane_align u_align (
    .off       (req_q.addr[1:0]),
    .size      (req_q.size),
    .uns       (req_q.uns),
    .wdata     (req_q.wdata),
    .rdata     (ram_data_out),
    .mask      (mask),
    .wdata_rep (wdata_rep),
    .rdata_ext (rdata_ext),
    .misalign  (misalign)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.if_resp_valid <= 1'b0;
      bus.if_resp_data  <= '0;
      bus.if_err        <= 1'b0;
      bus.ls_resp_valid <= 1'b0;
      bus.ls_resp_data  <= '0;
      bus.ls_err        <= 1'b0;
    end else begin
      bus.if_resp_valid <= 1'b0;
      bus.ls_resp_valid <= 1'b0;
      if (state == ACCESS) begin
        if (req_q.port == PORT_IF) begin
          bus.if_resp_valid <= 1'b1;
          bus.if_resp_data  <= misalign ? '0 : rdata_ext;
          bus.if_err        <= misalign;
        end else begin
          bus.ls_resp_valid <= 1'b1;
          bus.ls_resp_data  <= (misalign || req_q.we) ? '0 : rdata_ext;
          bus.ls_err        <= misalign;
        end
      end
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;
  localparam int AW = 24;

  typedef struct {
    logic          is_if;
    logic [AW+1:0] addr;
    logic          we;
    logic [1:0]    size;
    logic          uns;
    logic [31:0]   wdata;
    logic [31:0]   exp_data;
    logic          exp_err;
    logic          exp_wen;
    logic [3:0]    exp_wbe;
    logic [3:0]    exp_rbe;
    logic [31:0]   exp_din;
  } vec_t;

  logic          clk, rst, clr_mem;
  logic [AW-1:0] ram_sel_addr;
  logic [31:0]   ram_data_in, ram_data_out;
  logic [3:0]    ram_wbyte_enable, ram_rbyte_enable;
  logic          ram_wen;
  logic [31:0]   mem [0:255];
  int            checks = 0;
  int            errors = 0;
  vec_t          vecs[$];

  ram_port_arbiter_if #(.ADDR_W(AW)) bus ();

  ram_port_arbiter #(.ADDR_W(AW)) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus.slave),
    .ram_sel_addr     (ram_sel_addr),
    .ram_data_in      (ram_data_in),
    .ram_wbyte_enable (ram_wbyte_enable),
    .ram_rbyte_enable (ram_rbyte_enable),
    .ram_wen          (ram_wen),
    .ram_data_out     (ram_data_out)
  );

  always #5 clk = ~clk;

  // Bench RAM: combinational read, byte-enabled synchronous write.
  assign ram_data_out = mem[ram_sel_addr[7:0]];
  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (ram_wen) begin
      for (int b = 0; b < 4; b++)
        if (ram_wbyte_enable[b]) mem[ram_sel_addr[7:0]][8*b +: 8] <= ram_data_in[8*b +: 8];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(logic is_if, logic [AW+1:0] addr, logic we, logic [1:0] size,
                              logic uns, logic [31:0] wdata, logic [31:0] exp_data,
                              logic exp_err, logic exp_wen, logic [3:0] exp_wbe,
                              logic [3:0] exp_rbe, logic [31:0] exp_din);
    vec_t v;
    v.is_if = is_if; v.addr = addr; v.we = we; v.size = size; v.uns = uns;
    v.wdata = wdata; v.exp_data = exp_data; v.exp_err = exp_err; v.exp_wen = exp_wen;
    v.exp_wbe = exp_wbe; v.exp_rbe = exp_rbe; v.exp_din = exp_din;
    return v;
  endfunction

  task automatic clear_inputs();
    bus.if_req_valid = 0; bus.if_addr = '0;
    bus.ls_req_valid = 0; bus.ls_addr = '0; bus.ls_we = 0;
    bus.ls_size = 2'b00; bus.ls_unsigned = 0; bus.ls_wdata = '0;
  endtask

  // Issue one request, wait for its handshake, check the ACCESS-cycle RAM
  // drive and then the response cycle.
  task automatic run_vec(input int idx, input vec_t v);
    int n = 0;
    @(negedge clk);
    if (v.is_if) begin
      bus.if_req_valid = 1; bus.if_addr = v.addr;
    end else begin
      bus.ls_req_valid = 1; bus.ls_addr = v.addr; bus.ls_we = v.we;
      bus.ls_size = v.size; bus.ls_unsigned = v.uns; bus.ls_wdata = v.wdata;
    end
    #1;
    while (!(v.is_if ? bus.if_req_ready : bus.ls_req_ready) && n < 10) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 10) chk($sformatf("v%0d_ready_timeout", idx), 32'(n), 0);
    @(posedge clk); #1;
    clear_inputs();
    chk($sformatf("v%0d_wen", idx),  32'(ram_wen), 32'(v.exp_wen));
    chk($sformatf("v%0d_wbe", idx),  32'(ram_wbyte_enable), 32'(v.exp_wbe));
    chk($sformatf("v%0d_rbe", idx),  32'(ram_rbyte_enable), 32'(v.exp_rbe));
    chk($sformatf("v%0d_din", idx),  ram_data_in, v.exp_din);
    chk($sformatf("v%0d_sel", idx),  32'(ram_sel_addr), 32'(v.addr[AW+1:2]));
    @(posedge clk); #1;
    if (v.is_if) begin
      chk($sformatf("v%0d_if_vld", idx),  32'(bus.if_resp_valid), 1);
      chk($sformatf("v%0d_ls_vld", idx),  32'(bus.ls_resp_valid), 0);
      chk($sformatf("v%0d_data", idx),    bus.if_resp_data, v.exp_data);
      chk($sformatf("v%0d_err", idx),     32'(bus.if_err), 32'(v.exp_err));
    end else begin
      chk($sformatf("v%0d_ls_vld", idx),  32'(bus.ls_resp_valid), 1);
      chk($sformatf("v%0d_if_vld", idx),  32'(bus.if_resp_valid), 0);
      chk($sformatf("v%0d_data", idx),    bus.ls_resp_data, v.exp_data);
      chk($sformatf("v%0d_err", idx),     32'(bus.ls_err), 32'(v.exp_err));
    end
    chk($sformatf("v%0d_idle_drive", idx),
        {ram_wen, ram_wbyte_enable, ram_rbyte_enable}, 0);
  endtask

  initial begin
    clk = 0; rst = 1; clr_mem = 1;
    clear_inputs();

    //          if  addr     we size   u  wdata         data          err wen wbe      rbe      din
    vecs.push_back(mk(0, 26'h10, 1, 2'b10, 0, 32'hDEADBEEF, 32'h0,        0, 1, 4'b1111, 4'b0000, 32'hDEADBEEF));
    vecs.push_back(mk(1, 26'h10, 0, 2'b10, 0, 32'h0,        32'hDEADBEEF, 0, 0, 4'b0000, 4'b1111, 32'h0));
    vecs.push_back(mk(0, 26'h21, 1, 2'b00, 0, 32'h000000A5, 32'h0,        0, 1, 4'b0010, 4'b0000, 32'hA5A5A5A5));
    vecs.push_back(mk(0, 26'h21, 0, 2'b00, 0, 32'h0,        32'hFFFFFFA5, 0, 0, 4'b0000, 4'b0010, 32'h0));
    vecs.push_back(mk(0, 26'h21, 0, 2'b00, 1, 32'h0,        32'h000000A5, 0, 0, 4'b0000, 4'b0010, 32'h0));
    vecs.push_back(mk(0, 26'h12, 0, 2'b01, 0, 32'h0,        32'hFFFFDEAD, 0, 0, 4'b0000, 4'b1100, 32'h0));
    vecs.push_back(mk(0, 26'h10, 0, 2'b01, 1, 32'h0,        32'h0000BEEF, 0, 0, 4'b0000, 4'b0011, 32'h0));
    vecs.push_back(mk(0, 26'h13, 0, 2'b00, 0, 32'h0,        32'hFFFFFFDE, 0, 0, 4'b0000, 4'b1000, 32'h0));
    vecs.push_back(mk(0, 26'h03, 0, 2'b01, 0, 32'h0,        32'h0,        1, 0, 4'b0000, 4'b0000, 32'h0));
    vecs.push_back(mk(0, 26'h08, 1, 2'b10, 0, 32'h11223344, 32'h0,        0, 1, 4'b1111, 4'b0000, 32'h11223344));
    vecs.push_back(mk(0, 26'h08, 0, 2'b10, 0, 32'h0,        32'h11223344, 0, 0, 4'b0000, 4'b1111, 32'h0));
    vecs.push_back(mk(0, 26'h0E, 1, 2'b01, 0, 32'h1234BEEF, 32'h0,        0, 1, 4'b1100, 4'b0000, 32'hBEEFBEEF));
    vecs.push_back(mk(0, 26'h0C, 0, 2'b10, 0, 32'h0,        32'hBEEF0000, 0, 0, 4'b0000, 4'b1111, 32'h0));
    vecs.push_back(mk(1, 26'h11, 0, 2'b10, 0, 32'h0,        32'h0,        1, 0, 4'b0000, 4'b0000, 32'h0));
    vecs.push_back(mk(0, 26'h00, 0, 2'b11, 0, 32'h0,        32'h0,        1, 0, 4'b0000, 4'b0000, 32'h0));
    vecs.push_back(mk(0, 26'h02, 0, 2'b10, 0, 32'h0,        32'h0,        1, 0, 4'b0000, 4'b0000, 32'h0));
    vecs.push_back(mk(0, 26'h24, 1, 2'b00, 0, 32'hFFFFFF7F, 32'h0,        0, 1, 4'b0001, 4'b0000, 32'h7F7F7F7F));
    vecs.push_back(mk(0, 26'h24, 0, 2'b00, 0, 32'h0,        32'h0000007F, 0, 0, 4'b0000, 4'b0001, 32'h0));
    vecs.push_back(mk(0, 26'h05, 1, 2'b10, 0, 32'hFFFFFFFF, 32'h0,        1, 0, 4'b0000, 4'b0000, 32'h0));
    vecs.push_back(mk(0, 26'h04, 0, 2'b10, 0, 32'h0,        32'h0,        0, 0, 4'b0000, 4'b1111, 32'h0));

    // Reset state.
    #1;
    chk("rst_if_vld",   32'(bus.if_resp_valid), 0);
    chk("rst_ls_vld",   32'(bus.ls_resp_valid), 0);
    chk("rst_if_data",  bus.if_resp_data, 0);
    chk("rst_ls_data",  bus.ls_resp_data, 0);
    chk("rst_errs",     {bus.if_err, bus.ls_err}, 0);
    chk("rst_drive",    {ram_wen, ram_wbyte_enable, ram_rbyte_enable}, 0);
    chk("rst_sel",      32'(ram_sel_addr), 0);
    chk("rst_din",      ram_data_in, 0);
    chk("rst_if_ready", 32'(bus.if_req_ready), 1);
    chk("rst_ls_ready", 32'(bus.ls_req_ready), 0);
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst = 0; clr_mem = 0;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Round robin: both ports valid continuously from reset.
    @(negedge clk); rst = 1;
    @(posedge clk);
    @(negedge clk); rst = 0;
    bus.if_req_valid = 1; bus.if_addr = 26'h10;
    bus.ls_req_valid = 1; bus.ls_addr = 26'h08; bus.ls_we = 0; bus.ls_size = 2'b10;
    for (int k = 0; k <= 8; k++) begin
      logic ei, el;
      #1;
      ei = (k == 2 || k == 6);
      el = (k == 4 || k == 8);
      chk($sformatf("rr%0d_if_ready", k), 32'(bus.if_req_ready), 32'(k % 4 == 0));
      chk($sformatf("rr%0d_ls_ready", k), 32'(bus.ls_req_ready), 32'(k % 4 == 2));
      chk($sformatf("rr%0d_if_vld", k),   32'(bus.if_resp_valid), 32'(ei));
      chk($sformatf("rr%0d_ls_vld", k),   32'(bus.ls_resp_valid), 32'(el));
      if (ei) chk($sformatf("rr%0d_if_data", k), bus.if_resp_data, 32'hDEADBEEF);
      if (el) chk($sformatf("rr%0d_ls_data", k), bus.ls_resp_data, 32'h11223344);
      if (k == 8) clear_inputs();
      @(negedge clk);
    end

    // Reset during the ACCESS cycle of a word store.
    bus.ls_req_valid = 1; bus.ls_addr = 26'h10; bus.ls_we = 1;
    bus.ls_size = 2'b10; bus.ls_wdata = 32'hCAFEF00D;
    #1;
    chk("ra_ls_ready", 32'(bus.ls_req_ready), 1);
    @(posedge clk); #1;
    clear_inputs();
    chk("ra_wen_before", 32'(ram_wen), 1);
    rst = 1; #1;
    chk("ra_wen_after", 32'(ram_wen), 0);
    chk("ra_wbe_after", 32'(ram_wbyte_enable), 0);
    @(posedge clk); #1;
    chk("ra_no_resp", {bus.if_resp_valid, bus.ls_resp_valid}, 0);
    chk("ra_mem_kept", mem[4], 32'hDEADBEEF);
    @(negedge clk); rst = 0;
    run_vec(99, mk(1, 26'h10, 0, 2'b10, 0, 32'h0, 32'hDEADBEEF, 0, 0, 4'b0000, 4'b1111, 32'h0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester controller for the single-port 32-bit, 24-bit-word-address RAM (`ram_w32_addr24`). It shares the RAM between the instruction-fetch port and the load/store port using round-robin arbitration. It also converts byte addresses and access sizes into byte-lane enables, write-data replication, and read-data alignment with sign or zero extension. It sits between the CPU core and the RAM, and it is the only block that drives the RAM's address, data, enable and write-enable inputs.

## Interface
- `ADDR_W`, default 24: RAM word-address width. Byte addresses are `ADDR_W+2` bits.
- `clk` in 1: the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `if_req_valid` in 1, `if_req_ready` out 1, `if_addr` in ADDR_W+2: fetch request. Always a 32-bit read.
- `if_resp_valid` out 1, `if_resp_data` out 32, `if_err` out 1: fetch response. One-cycle pulse.
- `ls_req_valid` in 1, `ls_req_ready` out 1, `ls_addr` in ADDR_W+2: load/store request handshake and address.
- `ls_we` in 1: 1 = store.
- `ls_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `ls_unsigned` in 1: loads only; 1 = zero-extend.
- `ls_wdata` in 32: store data, low-aligned.
- `ls_resp_valid` out 1, `ls_resp_data` out 32, `ls_err` out 1: load/store response. One-cycle pulse.
- `ram_sel_addr` out ADDR_W, `ram_data_in` out 32, `ram_wbyte_enable` out 4, `ram_rbyte_enable` out 4, `ram_wen` out 1: RAM drive.
- `ram_data_out` in 32: combinational RAM read data.

## Operation
- FSM has two states:
  - IDLE: accepts one request.
  - ACCESS: drives the RAM for exactly one cycle, then always returns to IDLE.
- Readies:
  - `if_req_ready` = IDLE && grant_if.
  - `ls_req_ready` = IDLE && !grant_if.
  - Requesters must not make `valid` depend on `ready`.
- Grant rule in IDLE:
  - Only one port valid: that port is granted.
  - Both valid: the port not served last is granted.
  - Neither valid: grant_if = 1.
  - `last_if` updates on every accepted request and resets to 0, so the first tie goes to fetch.
- On handshake, latch port, addr, we, size, unsigned and wdata. Go to ACCESS.
- Lane mask by size:
  - byte: 0001 << a[1:0]
  - half: 0011 << a[1:0]
  - word: 1111
- Misaligned request is an error:
  - half with a[0]=1
  - word or fetch with a[1:0]≠0
  - any request with size 11
- On error in ACCESS: `ram_wen` = 0, both enables 0, response has err=1 and data 0.
- Store in ACCESS:
  - `ram_wen` = 1, `ram_wbyte_enable` = mask.
  - `ram_data_in` = {4{wdata[7:0]}} for byte, {2{wdata[15:0]}} for half, wdata for word.
  - Response data is 0.
- Load or fetch in ACCESS:
  - `ram_rbyte_enable` = mask.
  - Result = `ram_data_out` >> (8·a[1:0]), then sign- or zero-extended from bit 7 or 15. Fetch is never extended.
- `ram_sel_addr` = latched a[ADDR_W+1:2].
- `ram_wen` and both enables are 0 outside ACCESS. They decode combinationally from state.

## Timing
- Cycle 0: handshake.
- Cycle 1: ACCESS; RAM driven. The write commits at the end of cycle 1.
- Cycle 2: resp_valid = 1 with registered data and err. FSM is already in IDLE and may accept a new request in the same cycle.
- Peak throughput: one access every 2 cycles.
- Responses cannot be back-pressured.
- A load issued immediately after a store to the same word returns the new data.
- Reset values: state IDLE, `last_if` 0, both resp_valid 0, resp_data 0, err 0.
- RAM drive in reset: `ram_wen` 0, enables 0, `ram_sel_addr` 0, `ram_data_in` 0.
- Reset asserted during ACCESS: `ram_wen` falls immediately, no write commits, and no response is issued.

## Structure
- Package `mem_pkg` holds:
  - size constants SZ_B, SZ_H, SZ_W
  - the FSM state enum (IDLE, ACCESS)
  - the port enum (PORT_IF, PORT_LS)
- Natural sub-module: `mem_lane_align`. It is purely combinational and computes mask, write replication, read shift/extend and the misalign flag. Instantiate it once, fed from the latched request.

## Test plan
- Fetch `if_addr`=0x000010 with RAM word 4 = 0xDEADBEEF → cycle 2: `if_resp_valid`=1, `if_resp_data`=0xDEADBEEF, `if_err`=0.
- Store byte 0xA5 to 0x000021, then load byte signed from 0x000021 → `ram_wbyte_enable`=0010, `ram_data_in`=0xA5A5A5A5; load returns 0xFFFFFFA5. Unsigned load returns 0x000000A5.
- Both ports valid every cycle from reset → grants alternate IF, LS, IF, LS; each port gets one response per 4 cycles.
- Half load at 0x000003 → `ls_err`=1, `ls_resp_data`=0, `ram_wen` and enables stay 0 throughout.
- Word store at 0x000008, 0x11223344, back-to-back with word load at 0x000008 → load returns 0x11223344.
- Assert `rst` during the ACCESS of a word store → `ram_wen` drops in the same cycle, no response, and the RAM word is unchanged.
